// File: rtl/fixp_accum_mc.sv
// Multi-channel signed fixed-point accumulator with saturation/wrap, sticky
// overflow flags and a sequential dump engine that can clear channels as read.
module fixp_accum_mc #(
  parameter int IN_INT   = 4,
  parameter int FRAC     = 12,
  parameter int ACC_INT  = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 1,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW      = ACC_INT + FRAC,
  localparam int IW      = IN_INT + FRAC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [IW-1:0] data_in,
  input  logic                 data_en,
  input  logic [CH_W-1:0]      data_ch,
  input  logic                 clear_en,
  input  logic                 dump_start,
  input  logic                 dump_clear,
  output logic                 busy,
  output logic                 out_valid,
  output logic [CH_W-1:0]      out_ch,
  output logic signed [AW-1:0] data_out,
  output logic                 out_ovf,
  output logic [CHANNELS-1:0]  ovf
);

  typedef enum logic {IDLE, DUMP} state_t;

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  state_t            state_reg;
  logic [CH_W-1:0]   idx_reg;
  logic              mode_reg;
  logic [AW-1:0]     acc_arr [CHANNELS];
  logic [AW:0]       data_ext;
  logic              idle;

  assign idle     = (state_reg == IDLE);
  assign data_ext = {{(AW+1-IW){data_in[IW-1]}}, data_in};

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_ch
      logic [AW-1:0] acc_reg;
      logic          ovf_reg;
      logic [AW:0]   sum;
      logic          sum_ovf;
      logic [AW-1:0] sum_res;
      logic          sel;
      logic          dump_clr;

      always_comb begin
        sum     = {acc_reg[AW-1], acc_reg} + data_ext;
        sum_ovf = sum[AW] ^ sum[AW-1];
        sum_res = sum[AW-1:0];
        if (sum_ovf && (SATURATE != 0))
          sum_res = sum[AW] ? ACC_MIN : ACC_MAX;
        // Out-of-range data_ch never matches any gi, so it is silently ignored.
        sel      = idle && (data_ch == CH_W'(gi));
        dump_clr = (state_reg == DUMP) && mode_reg && (idx_reg == CH_W'(gi));
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          acc_reg <= '0;
          ovf_reg <= 1'b0;
        end else if ((sel && clear_en) || dump_clr) begin
          acc_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (sel && data_en) begin
          acc_reg <= sum_res;
          if (sum_ovf)
            ovf_reg <= 1'b1;
        end
      end

      assign acc_arr[gi] = acc_reg;
      assign ovf[gi]     = ovf_reg;
    end
  endgenerate

  // Dump engine: one channel per cycle; the final emission returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      mode_reg  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      data_out  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          out_valid <= 1'b0;
          if (dump_start) begin
            state_reg <= DUMP;
            idx_reg   <= '0;
            mode_reg  <= dump_clear;
            busy      <= 1'b1;
          end
        end
        DUMP: begin
          out_valid <= 1'b1;
          out_ch    <= idx_reg;
          data_out  <= acc_arr[idx_reg];
          out_ovf   <= ovf[idx_reg];
          if (idx_reg == CH_W'(CHANNELS - 1)) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixp_accum_mc.sv
// Bench for fixp_accum_mc: a saturating 4-channel instance and a wrapping
// 3-channel instance share stimulus and are checked against an integer model.
module tb_fixp_accum_mc;

  typedef logic signed [63:0] val_t;

  localparam val_t MAXV = 524287;    // 2^19 - 1
  localparam val_t MINV = -524288;   // -2^19
  localparam val_t SPAN = 1048576;   // 2^20

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] data_in = '0;
  logic               data_en = 1'b0;
  logic [1:0]         data_ch = '0;
  logic               clear_en = 1'b0;
  logic               dump_start = 1'b0;
  logic               dump_clear = 1'b0;

  logic               busy0, out_valid0, out_ovf0;
  logic [1:0]         out_ch0;
  logic signed [19:0] data_out0;
  logic [3:0]         ovf0;
  logic               busy1, out_valid1, out_ovf1;
  logic [1:0]         out_ch1;
  logic signed [19:0] data_out1;
  logic [2:0]         ovf1;

  fixp_accum_mc u_sat (
    .clk(clk), .reset(reset), .data_in(data_in), .data_en(data_en),
    .data_ch(data_ch), .clear_en(clear_en), .dump_start(dump_start),
    .dump_clear(dump_clear), .busy(busy0), .out_valid(out_valid0),
    .out_ch(out_ch0), .data_out(data_out0), .out_ovf(out_ovf0), .ovf(ovf0)
  );

  fixp_accum_mc #(.CHANNELS(3), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .data_in(data_in), .data_en(data_en),
    .data_ch(data_ch), .clear_en(clear_en), .dump_start(dump_start),
    .dump_clear(dump_clear), .busy(busy1), .out_valid(out_valid1),
    .out_ch(out_ch1), .data_out(data_out1), .out_ovf(out_ovf1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  val_t m_acc [2][4];
  bit   m_ovf [2][4];

  function automatic int nch(int u);
    return (u == 0) ? 4 : 3;
  endfunction

  function automatic void m_clear_all();
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < 4; c++) begin
        m_acc[u][c] = 0;
        m_ovf[u][c] = 1'b0;
      end
  endfunction

  function automatic void m_add(int u, int ch, val_t s);
    val_t r;
    if (ch >= nch(u)) return;
    r = m_acc[u][ch] + s;
    if (r > MAXV || r < MINV) begin
      m_ovf[u][ch] = 1'b1;
      if (u == 0) r = (r > MAXV) ? MAXV : MINV;
      else        r = ((r - MINV) % SPAN + SPAN) % SPAN + MINV;
    end
    m_acc[u][ch] = r;
  endfunction

  function automatic void m_clr(int u, int ch);
    if (ch >= nch(u)) return;
    m_acc[u][ch] = 0;
    m_ovf[u][ch] = 1'b0;
  endfunction

  task automatic chk(string tag, val_t obs, val_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ovf();
    val_t e0 = 0, e1 = 0;
    for (int c = 0; c < 4; c++) e0[c] = m_ovf[0][c];
    for (int c = 0; c < 3; c++) e1[c] = m_ovf[1][c];
    chk("ovf_sat", val_t'(ovf0), e0);
    chk("ovf_wrap", val_t'(ovf1), e1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    m_clear_all();
    $display("reset");
  endtask

  task automatic add(int ch, val_t s);
    data_ch = 2'(ch);
    data_in = s[15:0];
    data_en = 1'b1;
    cyc();
    data_en = 1'b0;
    m_add(0, ch, s);
    m_add(1, ch, s);
    $display("add ch=%0d s=%0d sat_ovf=%b wrap_ovf=%b", ch, s, ovf0, ovf1);
    check_ovf();
  endtask

  task automatic clr(int ch, bit with_add, val_t s);
    data_ch  = 2'(ch);
    data_in  = s[15:0];
    clear_en = 1'b1;
    data_en  = with_add;
    cyc();
    clear_en = 1'b0;
    data_en  = 1'b0;
    m_clr(0, ch);
    m_clr(1, ch);
    $display("clear ch=%0d with_add=%0d", ch, with_add);
    check_ovf();
  endtask

  task automatic chk_out(int u, int t, bit mode, logic v, logic [1:0] c,
                         logic signed [19:0] d, logic o);
    if (t < nch(u)) begin
      chk($sformatf("u%0d_t%0d_valid", u, t), val_t'(v), 1);
      chk($sformatf("u%0d_t%0d_ch", u, t), val_t'(c), t);
      chk($sformatf("u%0d_t%0d_data", u, t), val_t'(d), m_acc[u][t]);
      chk($sformatf("u%0d_t%0d_ovf", u, t), val_t'(o), val_t'(m_ovf[u][t]));
      if (mode) m_clr(u, t);
    end else begin
      chk($sformatf("u%0d_t%0d_idle", u, t), val_t'(v), 0);
    end
  endtask

  // Dump both instances; optionally add a sample in the dump_start cycle and
  // always try a write while busy, which must be ignored.
  task automatic dump(bit mode, bit co_add, int ch, val_t s);
    dump_start = 1'b1;
    dump_clear = mode;
    if (co_add) begin
      data_en = 1'b1;
      data_ch = 2'(ch);
      data_in = s[15:0];
    end
    cyc();
    dump_start = 1'b0;
    dump_clear = 1'b0;
    data_en    = 1'b0;
    if (co_add) begin
      m_add(0, ch, s);
      m_add(1, ch, s);
    end
    chk("busy_sat_start", val_t'(busy0), 1);
    chk("busy_wrap_start", val_t'(busy1), 1);
    chk("valid_sat_start", val_t'(out_valid0), 0);
    for (int t = 0; t < 5; t++) begin
      cyc();
      chk_out(0, t, mode, out_valid0, out_ch0, data_out0, out_ovf0);
      chk_out(1, t, mode, out_valid1, out_ch1, data_out1, out_ovf1);
      if (t == 0) begin
        chk("busy_sat_first", val_t'(busy0), 1);
        data_en  = 1'b1;
        clear_en = 1'b1;
        data_ch  = 2'($urandom_range(0, 3));
        data_in  = 16'h1000;
      end else if (t == 1) begin
        data_en  = 1'b0;
        clear_en = 1'b0;
      end
    end
    chk("busy_sat_end", val_t'(busy0), 0);
    chk("busy_wrap_end", val_t'(busy1), 0);
    $display("dump mode=%0d co_add=%0d last_sat=%0d last_wrap=%0d",
             mode, co_add, data_out0, data_out1);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_busy", val_t'(busy0), 0);
    chk("rst_valid", val_t'(out_valid0), 0);
    chk("rst_ch", val_t'(out_ch0), 0);
    chk("rst_data", val_t'(data_out0), 0);
    chk("rst_oovf", val_t'(out_ovf0), 0);
    chk("rst_valid_wrap", val_t'(out_valid1), 0);
    check_ovf();

    // Basic sum and dump: ch0 = 3.0
    for (int i = 0; i < 3; i++) begin
      add(0, 4096);
      cyc();
    end
    dump(1'b0, 1'b0, 0, 0);
    chk("basic_ch0", m_acc[0][0], 12288);
    chk("basic_ch0_wrap", m_acc[1][0], 12288);

    // Saturation on ch1/ch2, then back off ch1
    do_reset();
    for (int i = 0; i < 20; i++) add(1, 32767);
    for (int i = 0; i < 20; i++) add(2, -32768);
    add(1, -32768);
    dump(1'b0, 1'b0, 0, 0);

    // Wrap: ch0 += max positive sample 17 times
    do_reset();
    for (int i = 0; i < 17; i++) add(0, 32767);
    dump(1'b0, 1'b0, 0, 0);

    // Dump-clear then a dump of all zeros
    do_reset();
    for (int c = 0; c < 4; c++)
      for (int k = 0; k <= c; k++) add(c, 4096);
    dump(1'b1, 1'b0, 0, 0);
    dump(1'b0, 1'b0, 0, 0);

    // Priority, out-of-range channel on the 3-channel instance, co-add at start
    for (int i = 0; i < 5; i++) add(3, 4096);
    clr(3, 1'b1, 4096);
    add(3, 4096);
    dump(1'b0, 1'b1, 2, -4096);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int   op;
      int   ch;
      val_t s;
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, 3);
      s  = val_t'($signed(16'($urandom)));
      if (op < 7)      add(ch, s);
      else if (op < 8) clr(ch, 1'b0, s);
      else if (op < 9) clr(ch, 1'b1, s);
      else             dump(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ch, s);
    end
    dump(1'b0, 1'b0, 0, 0);

    // Reset mid-dump
    for (int c = 0; c < 4; c++) add(c, 8192);
    dump_start = 1'b1;
    cyc();
    dump_start = 1'b0;
    cyc();
    cyc();
    chk("mid_ch1_valid", val_t'(out_valid0), 1);
    chk("mid_ch1_idx", val_t'(out_ch0), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_clear_all();
    chk("mid_valid", val_t'(out_valid0), 0);
    chk("mid_busy", val_t'(busy0), 0);
    chk("mid_data", val_t'(data_out0), 0);
    chk("mid_busy_wrap", val_t'(busy1), 0);
    cyc();
    cyc();
    chk("mid_valid_after", val_t'(out_valid0), 0);
    chk("mid_valid_after_wrap", val_t'(out_valid1), 0);
    $display("reset mid-dump");
    dump(1'b0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
